// File: rtl/matrix_operand_loader.sv
// Matrix operand loader: collects four A bytes and four B bytes from a byte
// stream, presents them as packed 2x2 matrices, pulses start for one cycle,
// then waits for the downstream multiplier to report done.  A missing done
// sets a sticky err after TIMEOUT wait cycles.
module matrix_operand_loader #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        start,
    input  logic        done,
    output logic        busy,
    output logic        err,
    output logic [7:0]  op_count
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] ISSUE  = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    idx;
    logic [CW-1:0] wait_count;

    // Handshake and status outputs are pure decodes of the registered state
    assign in_ready = (state == LOAD_A) || (state == LOAD_B);
    assign start    = (state == ISSUE);
    assign busy     = (state == ISSUE) || (state == WAIT);

    // Main sequencer: byte capture, issue pulse, and done/timeout handling
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD_A;
            idx        <= 2'd0;
            wait_count <= '0;
            a          <= 32'd0;
            b          <= 32'd0;
            op_count   <= 8'd0;
            err        <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_valid) begin
                        case (idx)
                            2'd0:    a[31:24] <= in_data;
                            2'd1:    a[23:16] <= in_data;
                            2'd2:    a[15:8]  <= in_data;
                            default: a[7:0]   <= in_data;
                        endcase
                        if (idx == 2'd3) begin
                            state <= LOAD_B;
                            idx   <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        case (idx)
                            2'd0:    b[31:24] <= in_data;
                            2'd1:    b[23:16] <= in_data;
                            2'd2:    b[15:8]  <= in_data;
                            default: b[7:0]   <= in_data;
                        endcase
                        if (idx == 2'd3) begin
                            state <= ISSUE;
                            idx   <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                ISSUE: begin
                    // done is deliberately not looked at here
                    state      <= WAIT;
                    wait_count <= '0;
                end
                default: begin
                    // done wins over timeout when both land on the same cycle
                    if (done) begin
                        state    <= LOAD_A;
                        idx      <= 2'd0;
                        op_count <= op_count + 8'd1;
                    end else if (wait_count == WAIT_LAST) begin
                        state <= LOAD_A;
                        idx   <= 2'd0;
                        err   <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
